handshake_memory: RTL and testbench

Parametrised byte-addressed RAM: the valid/ready successor to the fixed 32-bit simple memory. It offers independent read and write channels with configurable data width, depth and read latency, and reports access errors. The top word is a mailbox, which is reset and exported continuously for testbench and host signalling. It sits between the core's load/store unit and the simulation top.

---
 rtl/handshake_memory.sv | 178 +++++++++++++++++
 tb/tb_handshake_memory.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_memory.sv
// handshake_memory: byte-addressed RAM with independent valid/ready read and write channels.
// Optional HANDSHAKE_MEMORY_ALIGN_CHECK_EN: addresses not aligned to pDataBytes are access errors.
module handshake_memory #(
    parameter int pWords       = 128,
    parameter int pDataBytes   = 4,
    parameter int pReadLatency = 1
) (
    input  logic                    iwClk,
    input  logic                    iwnRst,
    input  logic                    iwRdValid,
    output logic                    owRdReady,
    input  logic [31:0]             iwRdAddr,
    output logic                    orRdRespValid,
    output logic [8*pDataBytes-1:0] orRdData,
    output logic                    orRdErr,
    input  logic                    iwWrValid,
    output logic                    owWrReady,
    input  logic [31:0]             iwWrAddr,
    input  logic [8*pDataBytes-1:0] iwWrData,
    input  logic [pDataBytes-1:0]   iwWstrb,
    output logic                    orWrRespValid,
    output logic                    orWrErr,
    output logic [8*pDataBytes-1:0] owLastData,
    output logic                    orMailboxPulse
);

    localparam int TOTAL   = pWords * pDataBytes;
    localparam int MB_BASE = TOTAL - pDataBytes;
    localparam int AW      = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int DW      = 8 * pDataBytes;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} rd_state_t;

    logic [7:0]  mem_r [TOTAL];
    logic        alive_r;
    rd_state_t   rd_state_r;
    logic [3:0]  rd_cnt_r;
    logic [31:0] rd_addr_r;

    logic          rd_fire_s, samp_now_s, samp_err_s;
    logic [31:0]   samp_addr_s;
    logic [DW-1:0] samp_data_s;
    logic          wr_fire_s, wr_err_s, wr_mb_s;

    // 33-bit range check so addresses near 2^32 cannot wrap back into range
    function automatic logic addr_err(input logic [31:0] addr);
        logic err;
        err = ({1'b0, addr} + 33'(pDataBytes)) > 33'(TOTAL);
`ifdef HANDSHAKE_MEMORY_ALIGN_CHECK_EN
        err = err | ((addr & 32'(pDataBytes - 1)) != 32'd0);
`endif
        return err;
    endfunction

    function automatic logic [AW-1:0] lane_idx(input logic [31:0] addr, input int lane);
        return AW'(addr + 32'(lane));
    endfunction

    assign owWrReady = alive_r;
    assign owRdReady = alive_r && (rd_state_r == ST_IDLE);
    assign rd_fire_s = iwRdValid && owRdReady;

    // Read sampling: address source and whether this edge enters RESP
    always_comb begin
        samp_addr_s = rd_addr_r;
        samp_now_s  = 1'b0;
        case (rd_state_r)
            ST_IDLE: begin
                samp_addr_s = iwRdAddr;
                samp_now_s  = rd_fire_s && (pReadLatency == 1);
            end
            ST_WAIT: samp_now_s = (rd_cnt_r == 4'd1);
            ST_RESP: samp_now_s = 1'b0;
            default: samp_now_s = 1'b0;
        endcase
        samp_err_s  = addr_err(samp_addr_s);
        samp_data_s = {DW{1'b0}};
        for (int i = 0; i < pDataBytes; i++) begin
            if (samp_err_s) begin
                samp_data_s[8*i +: 8] = 8'h00;
            end else begin
                samp_data_s[8*i +: 8] = mem_r[lane_idx(samp_addr_s, i)];
            end
        end
    end

    // Write decode: acceptance, error and whether any enabled lane hits the mailbox
    always_comb begin
        wr_fire_s = iwWrValid && alive_r;
        wr_err_s  = addr_err(iwWrAddr);
        wr_mb_s   = 1'b0;
        for (int i = 0; i < pDataBytes; i++) begin
            if (iwWstrb[i] && (lane_idx(iwWrAddr, i) >= AW'(MB_BASE))) begin
                wr_mb_s = 1'b1;
            end else begin
                wr_mb_s = wr_mb_s;
            end
        end
    end

    // Mailbox export straight from storage
    always_comb begin
        owLastData = {DW{1'b0}};
        for (int i = 0; i < pDataBytes; i++) begin
            owLastData[8*i +: 8] = mem_r[AW'(MB_BASE + i)];
        end
    end

    // Storage: only mailbox bytes are cleared by reset, the rest hold their contents
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            for (int i = 0; i < pDataBytes; i++) begin
                mem_r[AW'(MB_BASE + i)] <= 8'h00;
            end
        end else if (wr_fire_s && !wr_err_s) begin
            for (int i = 0; i < pDataBytes; i++) begin
                if (iwWstrb[i]) begin
                    mem_r[lane_idx(iwWrAddr, i)] <= iwWrData[8*i +: 8];
                end
            end
        end
    end

    // Write response and channel enable
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            alive_r        <= 1'b0;
            orWrRespValid  <= 1'b0;
            orWrErr        <= 1'b0;
            orMailboxPulse <= 1'b0;
        end else begin
            alive_r        <= 1'b1;
            orWrRespValid  <= wr_fire_s;
            orWrErr        <= wr_fire_s && wr_err_s;
            orMailboxPulse <= wr_fire_s && !wr_err_s && wr_mb_s;
        end
    end

    // Read FSM with latency counter; data/error captured on the edge entering RESP
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            rd_state_r    <= ST_IDLE;
            rd_cnt_r      <= 4'd0;
            rd_addr_r     <= 32'd0;
            orRdRespValid <= 1'b0;
            orRdData      <= {DW{1'b0}};
            orRdErr       <= 1'b0;
        end else begin
            orRdRespValid <= (rd_state_r == ST_RESP);
            if (samp_now_s) begin
                orRdData <= samp_data_s;
                orRdErr  <= samp_err_s;
            end
            case (rd_state_r)
                ST_IDLE: begin
                    if (rd_fire_s) begin
                        rd_addr_r <= iwRdAddr;
                        rd_cnt_r  <= 4'(pReadLatency - 1);
                        if (pReadLatency == 1) begin
                            rd_state_r <= ST_RESP;
                        end else begin
                            rd_state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    rd_cnt_r <= rd_cnt_r - 4'd1;
                    if (rd_cnt_r == 4'd1) begin
                        rd_state_r <= ST_RESP;
                    end
                end
                ST_RESP: rd_state_r <= ST_IDLE;
                default: rd_state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_memory.sv
// Scoreboard bench for handshake_memory: byte-array reference model, random and directed traffic.
module tb_handshake_memory;

    localparam int PW  = 128;
    localparam int PB  = 4;
    localparam int L   = 3;
    localparam int TOT = PW * PB;
    localparam int MB  = TOT - PB;

    logic        iwClk = 1'b0;
    logic        iwnRst = 1'b0;
    logic        iwRdValid = 1'b0;
    logic        owRdReady;
    logic [31:0] iwRdAddr = 32'd0;
    logic        orRdRespValid;
    logic [31:0] orRdData;
    logic        orRdErr;
    logic        iwWrValid = 1'b0;
    logic        owWrReady;
    logic [31:0] iwWrAddr = 32'd0;
    logic [31:0] iwWrData = 32'd0;
    logic [3:0]  iwWstrb = 4'd0;
    logic        orWrRespValid;
    logic        orWrErr;
    logic [31:0] owLastData;
    logic        orMailboxPulse;

    handshake_memory #(.pWords(PW), .pDataBytes(PB), .pReadLatency(L)) dut (
        .iwClk(iwClk), .iwnRst(iwnRst),
        .iwRdValid(iwRdValid), .owRdReady(owRdReady), .iwRdAddr(iwRdAddr),
        .orRdRespValid(orRdRespValid), .orRdData(orRdData), .orRdErr(orRdErr),
        .iwWrValid(iwWrValid), .owWrReady(owWrReady), .iwWrAddr(iwWrAddr),
        .iwWrData(iwWrData), .iwWstrb(iwWstrb),
        .orWrRespValid(orWrRespValid), .orWrErr(orWrErr),
        .owLastData(owLastData), .orMailboxPulse(orMailboxPulse)
    );

    always #5 iwClk = ~iwClk;

    int edge_cnt = 0;
    always @(posedge iwClk) edge_cnt <= edge_cnt + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl [TOT];
    typedef struct {logic [31:0] addr; int samp; int resp;} pend_t;
    typedef struct {logic [31:0] data; logic err; int resp;} rd_t;
    typedef struct {logic err; logic pulse; logic [31:0] last; int resp;} wr_t;
    pend_t pend_q[$];
    rd_t   rd_q[$];
    wr_t   wr_q[$];
    int    rd_next_ok = 0;
    int    wr_ok = 0;

    function automatic bit acc_err(input logic [31:0] a);
        bit e;
        e = ({1'b0, a} + 33'd4) > 33'(TOT);
`ifdef HANDSHAKE_MEMORY_ALIGN_CHECK_EN
        e = e || ((a % 32'd4) != 32'd0);
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a response
    always @(negedge iwClk) begin
        rd_t r;
        wr_t w;
        if (orRdRespValid) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got response data %h, expected none", orRdData);
            end else begin
                r = rd_q.pop_front();
                chk("rd_data", orRdData, r.data);
                chk("rd_err", {31'd0, orRdErr}, {31'd0, r.err});
                chk("rd_latency", 32'(edge_cnt), 32'(r.resp));
            end
        end
        if (orWrRespValid) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got write response, expected none");
            end else begin
                w = wr_q.pop_front();
                chk("wr_err", {31'd0, orWrErr}, {31'd0, w.err});
                chk("mb_pulse", {31'd0, orMailboxPulse}, {31'd0, w.pulse});
                chk("last_data", owLastData, w.last);
                chk("wr_latency", 32'(edge_cnt), 32'(w.resp));
            end
        end else begin
            chk("mb_pulse_idle", {31'd0, orMailboxPulse}, 32'd0);
        end
    end

    // One cycle: drive at a negedge, predict what the upcoming edge does, advance
    task automatic step(input bit rv, input logic [31:0] ra, input bit wv,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
        bit    rdy;
        pend_t p;
        rd_t   r;
        wr_t   w;
        rdy = (edge_cnt >= rd_next_ok);
        chk("rd_ready", {31'd0, owRdReady}, {31'd0, rdy});
        chk("wr_ready", {31'd0, owWrReady}, {31'd0, edge_cnt >= wr_ok});
        iwRdValid = rv; iwRdAddr = ra;
        iwWrValid = wv; iwWrAddr = wa; iwWrData = wd; iwWstrb = ws;
        if (rv && rdy) begin
            p.addr = ra; p.samp = edge_cnt + L - 1; p.resp = edge_cnt + L + 1;
            pend_q.push_back(p);
            rd_next_ok = edge_cnt + L + 1;
        end
        while (pend_q.size() > 0 && pend_q[0].samp == edge_cnt) begin
            p = pend_q.pop_front();
            r.err  = acc_err(p.addr);
            r.data = 32'd0;
            if (!r.err) begin
                for (int i = 0; i < PB; i++) r.data[8*i +: 8] = mdl[int'(p.addr) + i];
            end
            r.resp = p.resp;
            rd_q.push_back(r);
        end
        if (wv && (edge_cnt >= wr_ok)) begin
            w.err   = acc_err(wa);
            w.pulse = 1'b0;
            if (!w.err) begin
                for (int i = 0; i < PB; i++) begin
                    if (ws[i]) begin
                        mdl[int'(wa) + i] = wd[8*i +: 8];
                        if (int'(wa) + i >= MB) w.pulse = 1'b1;
                    end
                end
            end
            for (int i = 0; i < PB; i++) w.last[8*i +: 8] = mdl[MB + i];
            w.resp = edge_cnt + 1;
            wr_q.push_back(w);
        end
        @(posedge iwClk);
        @(negedge iwClk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic do_reset(input int n);
        iwnRst = 1'b0;
        iwRdValid = 1'b0;
        iwWrValid = 1'b0;
        #1;
        pend_q.delete();
        rd_q.delete();
        wr_q.delete();
        for (int i = 0; i < PB; i++) mdl[MB + i] = 8'h00;
        repeat (n) @(negedge iwClk);
        chk("rst_rd_ready", {31'd0, owRdReady}, 32'd0);
        chk("rst_wr_ready", {31'd0, owWrReady}, 32'd0);
        chk("rst_rd_valid", {31'd0, orRdRespValid}, 32'd0);
        chk("rst_rd_data", orRdData, 32'd0);
        chk("rst_rd_err", {31'd0, orRdErr}, 32'd0);
        chk("rst_wr_valid", {31'd0, orWrRespValid}, 32'd0);
        chk("rst_wr_err", {31'd0, orWrErr}, 32'd0);
        chk("rst_last_data", owLastData, 32'd0);
        iwnRst = 1'b1;
        rd_next_ok = edge_cnt + 1;
        wr_ok = edge_cnt + 1;
    endtask

    initial begin
        @(negedge iwClk);
        do_reset(2);
        idle(2);
        // fill every word so all model bytes are known
        for (int w = 0; w < PW; w++) step(1'b0, 32'd0, 1'b1, 32'(w * 4), $urandom, 4'hF);
        idle(2);

        step(1'b0, 32'd0, 1'b1, 32'd0, 32'h11223344, 4'hF);
        step(1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0);
        idle(L + 1);
        step(1'b0, 32'd0, 1'b1, 32'd0, 32'hAABBCCDD, 4'b0101);
        step(1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0);
        idle(L + 1);

        step(1'b0, 32'd0, 1'b1, 32'd508, 32'hCAFEF00D, 4'hF);
        idle(2);
        do_reset(2);
        idle(1);
        step(1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0);
        idle(L + 1);
        step(1'b1, 32'd508, 1'b0, 32'd0, 32'd0, 4'd0);
        idle(L + 1);

        step(1'b1, 32'd509, 1'b1, 32'd512, 32'h01020304, 4'hF);
        idle(L + 1);
        step(1'b1, 32'd508, 1'b0, 32'd0, 32'd0, 4'd0);
        idle(L + 1);

        step(1'b0, 32'd0, 1'b1, 32'd2, 32'h5A5AA5A5, 4'hF);
        step(1'b1, 32'd2, 1'b0, 32'd0, 32'd0, 4'd0);
        idle(L + 1);
        step(1'b1, 32'd4, 1'b0, 32'd0, 32'd0, 4'd0);
        idle(L + 1);

        // reset while the read is in WAIT: its response must never appear
        step(1'b1, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0);
        idle(1);
        do_reset(2);
        idle(L + 5);

        for (int n = 0; n < 800; n++) begin
            step(1'($urandom_range(0, 1)), 32'($urandom_range(0, TOT + 3)),
                 ($urandom_range(0, 3) != 0), 32'($urandom_range(0, TOT + 3)),
                 $urandom, 4'($urandom_range(0, 15)));
        end
        idle(L + 3);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        chk("pend_queue_drained", 32'(pend_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
